// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - two-port (core LSU / debug) access sequencer for the RV32I data memory
// Grants one command at a time, drives width strobes, checks legality and extends load data.
module dmem_access_ctrl #(
    parameter int ADDR_W = 12
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_core_req,
    input  logic              i_core_we,
    input  logic [2:0]        i_core_funct3,
    input  logic [31:0]       i_core_addr,
    input  logic [31:0]       i_core_wdata,
    output logic              o_core_gnt,
    output logic              o_core_done,
    output logic [31:0]       o_core_rdata,
    output logic              o_core_err,
    input  logic              i_dbg_req,
    input  logic              i_dbg_we,
    input  logic [ADDR_W-1:0] i_dbg_addr,
    input  logic [31:0]       i_dbg_wdata,
    output logic              o_dbg_gnt,
    output logic              o_dbg_done,
    output logic [31:0]       o_dbg_rdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_we,
    output logic              o_mem_byte,
    output logic              o_mem_half,
    output logic              o_mem_word,
    output logic [31:0]       o_mem_wdata,
    input  logic [31:0]       i_mem_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        WAIT_RD = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic              r_last_dbg;
    logic              r_port_dbg;
    logic              r_we;
    logic [2:0]        r_funct3;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_core_err;
    logic [31:0]       r_core_rdata;
    logic [31:0]       r_dbg_rdata;

    logic              w_core_gnt;
    logic              w_dbg_gnt;
    logic              w_core_legal;
    logic              w_core_misal;
    logic              w_core_bad;
    logic [31:0]       w_load_ext;

    // Address bits above the memory window alias; debug addresses are word-aligned.
    logic              w_unused;
    assign w_unused = &{1'b0, i_core_addr[31:ADDR_W], i_dbg_addr[1:0]};

    always_comb begin
        w_core_legal = 1'b0;
        case ({i_core_we, i_core_funct3})
            4'b0_000, 4'b0_001, 4'b0_010, 4'b0_100, 4'b0_101,
            4'b1_000, 4'b1_001, 4'b1_010: w_core_legal = 1'b1;
            default:                      w_core_legal = 1'b0;
        endcase
    end

    assign w_core_misal = ((i_core_funct3[1:0] == 2'b01) && i_core_addr[0]) ||
                          ((i_core_funct3[1:0] == 2'b10) && (i_core_addr[1:0] != 2'b00));
    assign w_core_bad   = !w_core_legal || w_core_misal;

    // Round-robin of two: on contention the port not served last wins.
    assign w_core_gnt = (r_state == IDLE) && i_core_req && (!i_dbg_req || r_last_dbg);
    assign w_dbg_gnt  = (r_state == IDLE) && i_dbg_req && !w_core_gnt;

    always_comb begin
        w_load_ext = i_mem_rdata;
        case (r_funct3)
            3'b000:  w_load_ext = {{24{i_mem_rdata[7]}},  i_mem_rdata[7:0]};
            3'b001:  w_load_ext = {{16{i_mem_rdata[15]}}, i_mem_rdata[15:0]};
            3'b100:  w_load_ext = {24'd0, i_mem_rdata[7:0]};
            3'b101:  w_load_ext = {16'd0, i_mem_rdata[15:0]};
            default: w_load_ext = i_mem_rdata;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        o_core_gnt  = w_core_gnt;
        o_dbg_gnt   = w_dbg_gnt;
        o_mem_we    = 1'b0;
        o_mem_byte  = 1'b0;
        o_mem_half  = 1'b0;
        o_mem_word  = 1'b0;
        o_core_done = 1'b0;
        o_dbg_done  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_core_gnt) begin
                    w_next = w_core_bad ? RESP : ACCESS;
                end else if (w_dbg_gnt) begin
                    w_next = ACCESS;
                end
            end
            ACCESS: begin
                o_mem_we   = r_we;
                o_mem_byte = (r_funct3[1:0] == 2'b00);
                o_mem_half = (r_funct3[1:0] == 2'b01);
                o_mem_word = (r_funct3[1:0] == 2'b10);
                w_next     = r_we ? RESP : WAIT_RD;
            end
            WAIT_RD: begin
                w_next = RESP;
            end
            RESP: begin
                o_core_done = !r_port_dbg;
                o_dbg_done  = r_port_dbg;
                w_next      = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Address/data registers only load for commands that reach ACCESS, so the
    // memory bus holds its last values across error responses and idle time.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_dbg   <= 1'b1;
            r_port_dbg   <= 1'b0;
            r_we         <= 1'b0;
            r_funct3     <= 3'b000;
            r_addr       <= '0;
            r_wdata      <= 32'd0;
            r_core_err   <= 1'b0;
            r_core_rdata <= 32'd0;
            r_dbg_rdata  <= 32'd0;
        end else begin
            if (w_core_gnt) begin
                r_last_dbg <= 1'b0;
                r_port_dbg <= 1'b0;
                r_core_err <= w_core_bad;
                if (w_core_bad) begin
                    r_core_rdata <= 32'd0;
                end else begin
                    r_we     <= i_core_we;
                    r_funct3 <= i_core_funct3;
                    r_addr   <= i_core_addr[ADDR_W-1:0];
                    r_wdata  <= i_core_wdata;
                end
            end else if (w_dbg_gnt) begin
                r_last_dbg <= 1'b1;
                r_port_dbg <= 1'b1;
                r_we       <= i_dbg_we;
                r_funct3   <= 3'b010;
                r_addr     <= {i_dbg_addr[ADDR_W-1:2], 2'b00};
                r_wdata    <= i_dbg_wdata;
            end
            if (r_state == WAIT_RD) begin
                if (r_port_dbg) begin
                    r_dbg_rdata <= i_mem_rdata;
                end else begin
                    r_core_rdata <= w_load_ext;
                end
            end
        end
    end

    assign o_mem_addr   = r_addr;
    assign o_mem_wdata  = r_wdata;
    assign o_core_rdata = r_core_rdata;
    assign o_core_err   = r_core_err;
    assign o_dbg_rdata  = r_dbg_rdata;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - directed bench for dmem_access_ctrl with a byte-addressed memory model
module tb_dmem_access_ctrl;

    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              core_req = 1'b0;
    logic              core_we = 1'b0;
    logic [2:0]        core_f3 = 3'b000;
    logic [31:0]       core_addr = 32'd0;
    logic [31:0]       core_wdata = 32'd0;
    logic              o_core_gnt, o_core_done, o_core_err;
    logic [31:0]       o_core_rdata;
    logic              dbg_req = 1'b0;
    logic              dbg_we = 1'b0;
    logic [ADDR_W-1:0] dbg_addr = '0;
    logic [31:0]       dbg_wdata = 32'd0;
    logic              o_dbg_gnt, o_dbg_done;
    logic [31:0]       o_dbg_rdata;
    logic [ADDR_W-1:0] o_mem_addr;
    logic              o_mem_we, o_mem_byte, o_mem_half, o_mem_word;
    logic [31:0]       o_mem_wdata;
    logic [31:0]       mem_rdata = 32'd0;

    int n_vec = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    dmem_access_ctrl #(.ADDR_W(ADDR_W)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_core_req(core_req), .i_core_we(core_we), .i_core_funct3(core_f3),
        .i_core_addr(core_addr), .i_core_wdata(core_wdata),
        .o_core_gnt(o_core_gnt), .o_core_done(o_core_done),
        .o_core_rdata(o_core_rdata), .o_core_err(o_core_err),
        .i_dbg_req(dbg_req), .i_dbg_we(dbg_we), .i_dbg_addr(dbg_addr), .i_dbg_wdata(dbg_wdata),
        .o_dbg_gnt(o_dbg_gnt), .o_dbg_done(o_dbg_done), .o_dbg_rdata(o_dbg_rdata),
        .o_mem_addr(o_mem_addr), .o_mem_we(o_mem_we), .o_mem_byte(o_mem_byte),
        .o_mem_half(o_mem_half), .o_mem_word(o_mem_word), .o_mem_wdata(o_mem_wdata),
        .i_mem_rdata(mem_rdata)
    );

    // Memory model: registered read, unselected read bytes keep stale contents.
    logic [7:0] mem [0:4095];
    initial for (int i = 0; i < 4096; i++) mem[i] = 8'h00;

    always @(posedge clk) begin
        if (o_mem_we) begin
            if (o_mem_byte) mem[o_mem_addr] = o_mem_wdata[7:0];
            if (o_mem_half) begin
                mem[{o_mem_addr[11:1], 1'b0}] = o_mem_wdata[7:0];
                mem[{o_mem_addr[11:1], 1'b1}] = o_mem_wdata[15:8];
            end
            if (o_mem_word) begin
                mem[{o_mem_addr[11:2], 2'b00}] = o_mem_wdata[7:0];
                mem[{o_mem_addr[11:2], 2'b01}] = o_mem_wdata[15:8];
                mem[{o_mem_addr[11:2], 2'b10}] = o_mem_wdata[23:16];
                mem[{o_mem_addr[11:2], 2'b11}] = o_mem_wdata[31:24];
            end
        end else begin
            if (o_mem_byte) mem_rdata[7:0] <= mem[o_mem_addr];
            if (o_mem_half) mem_rdata[15:0] <= {mem[{o_mem_addr[11:1], 1'b1}], mem[{o_mem_addr[11:1], 1'b0}]};
            if (o_mem_word) mem_rdata <= {mem[{o_mem_addr[11:2], 2'b11}], mem[{o_mem_addr[11:2], 2'b10}],
                                          mem[{o_mem_addr[11:2], 2'b01}], mem[{o_mem_addr[11:2], 2'b00}]};
        end
    end

    task automatic core_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, output int done_cyc, output logic [31:0] rd,
                           output logic err, output int nstb);
        int cyc;
        done_cyc = -1; rd = 32'd0; err = 1'b0; nstb = 0;
        @(negedge clk);
        core_req = 1'b1; core_we = we; core_f3 = f3; core_addr = addr; core_wdata = wd;
        #1;
        cyc = 0;
        while (!o_core_gnt && cyc < 20) begin @(negedge clk); #1; cyc++; end
        if (o_core_gnt) begin
            for (int c = 1; c <= 12 && done_cyc < 0; c++) begin
                @(negedge clk);
                if (c == 1) core_req = 1'b0;
                #1;
                if (o_mem_byte || o_mem_half || o_mem_word) nstb++;
                if (o_core_done) begin done_cyc = c; rd = o_core_rdata; err = o_core_err; end
            end
        end
        core_req = 1'b0;
    endtask

    task automatic dbg_op(input logic we, input logic [ADDR_W-1:0] addr, input logic [31:0] wd,
                          output int done_cyc, output logic [31:0] rd);
        int cyc;
        done_cyc = -1; rd = 32'd0;
        @(negedge clk);
        dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wd;
        #1;
        cyc = 0;
        while (!o_dbg_gnt && cyc < 20) begin @(negedge clk); #1; cyc++; end
        if (o_dbg_gnt) begin
            for (int c = 1; c <= 12 && done_cyc < 0; c++) begin
                @(negedge clk);
                if (c == 1) dbg_req = 1'b0;
                #1;
                if (o_dbg_done) begin done_cyc = c; rd = o_dbg_rdata; end
            end
        end
        dbg_req = 1'b0;
    endtask

    // Both ports raise requests in the same cycle; reports which port was granted first and second.
    task automatic contend(output logic first_core, output logic second_core, output logic both_gnt);
        int cyc;
        first_core = 1'bx; second_core = 1'bx; both_gnt = 1'b0;
        @(negedge clk);
        core_req = 1'b1; core_we = 1'b0; core_f3 = 3'b010; core_addr = 32'h10;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 12'h010;
        #1;
        cyc = 0;
        while (!(o_core_gnt || o_dbg_gnt) && cyc < 20) begin @(negedge clk); #1; cyc++; end
        both_gnt = o_core_gnt && o_dbg_gnt;
        if (o_core_gnt || o_dbg_gnt) first_core = o_core_gnt;
        @(negedge clk);
        if (first_core === 1'b1) core_req = 1'b0;
        if (first_core === 1'b0) dbg_req = 1'b0;
        #1;
        cyc = 0;
        while (!(o_core_gnt || o_dbg_gnt) && cyc < 20) begin @(negedge clk); #1; cyc++; end
        if (o_core_gnt || o_dbg_gnt) second_core = o_core_gnt;
        @(negedge clk);
        core_req = 1'b0; dbg_req = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_vec++; if ({o_core_gnt, o_core_done, o_core_err, o_dbg_gnt, o_dbg_done} !== 5'b0) begin n_miss++; $display("FAIL reset_ctrl: got %b expected 00000", {o_core_gnt, o_core_done, o_core_err, o_dbg_gnt, o_dbg_done}); end
        n_vec++; if ({o_mem_we, o_mem_byte, o_mem_half, o_mem_word} !== 4'b0) begin n_miss++; $display("FAIL reset_strobes: got %b expected 0000", {o_mem_we, o_mem_byte, o_mem_half, o_mem_word}); end
        n_vec++; if ({o_core_rdata, o_dbg_rdata, o_mem_wdata} !== 96'd0 || o_mem_addr !== 12'd0) begin n_miss++; $display("FAIL reset_data: got %h %h %h %h expected zeros", o_core_rdata, o_dbg_rdata, o_mem_wdata, o_mem_addr); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_word_round_trip();
        int dc, ns; logic [31:0] rd; logic er;
        core_op(1'b1, 3'b010, 32'h010, 32'hDEADBEEF, dc, rd, er, ns);
        n_vec++; if (dc !== 2 || er !== 1'b0 || ns !== 1) begin n_miss++; $display("FAIL sw_timing: got done=%0d err=%b strobes=%0d expected 2 0 1", dc, er, ns); end
        core_op(1'b0, 3'b010, 32'h010, 32'h0, dc, rd, er, ns);
        n_vec++; if (dc !== 3 || er !== 1'b0) begin n_miss++; $display("FAIL lw_timing: got done=%0d err=%b expected 3 0", dc, er); end
        n_vec++; if (rd !== 32'hDEADBEEF) begin n_miss++; $display("FAIL lw_data: got %h expected deadbeef", rd); end
    endtask

    task automatic test_byte_extension();
        int dc, ns; logic [31:0] rd; logic er;
        core_op(1'b1, 3'b000, 32'h021, 32'h12345680, dc, rd, er, ns);
        n_vec++; if (dc !== 2 || er !== 1'b0) begin n_miss++; $display("FAIL sb: got done=%0d err=%b expected 2 0", dc, er); end
        core_op(1'b0, 3'b000, 32'h021, 32'h0, dc, rd, er, ns);
        n_vec++; if (rd !== 32'hFFFFFF80 || dc !== 3) begin n_miss++; $display("FAIL lb: got %h done=%0d expected ffffff80 3", rd, dc); end
        core_op(1'b0, 3'b100, 32'h021, 32'h0, dc, rd, er, ns);
        n_vec++; if (rd !== 32'h00000080) begin n_miss++; $display("FAIL lbu: got %h expected 00000080", rd); end
        core_op(1'b1, 3'b010, 32'h020, 32'h12348001, dc, rd, er, ns);
        core_op(1'b0, 3'b001, 32'h020, 32'h0, dc, rd, er, ns);
        n_vec++; if (rd !== 32'hFFFF8001 || er !== 1'b0) begin n_miss++; $display("FAIL lh: got %h err=%b expected ffff8001 0", rd, er); end
        core_op(1'b0, 3'b101, 32'h020, 32'h0, dc, rd, er, ns);
        n_vec++; if (rd !== 32'h00008001) begin n_miss++; $display("FAIL lhu: got %h expected 00008001", rd); end
    endtask

    task automatic test_errors();
        int dc, ns; logic [31:0] rd; logic er;
        core_op(1'b0, 3'b001, 32'h003, 32'h0, dc, rd, er, ns);
        n_vec++; if (dc !== 1 || er !== 1'b1 || rd !== 32'd0 || ns !== 0) begin n_miss++; $display("FAIL lh_misaligned: got done=%0d err=%b rdata=%h strobes=%0d expected 1 1 0 0", dc, er, rd, ns); end
        core_op(1'b0, 3'b011, 32'h010, 32'h0, dc, rd, er, ns);
        n_vec++; if (dc !== 1 || er !== 1'b1 || rd !== 32'd0 || ns !== 0) begin n_miss++; $display("FAIL f3_011: got done=%0d err=%b rdata=%h strobes=%0d expected 1 1 0 0", dc, er, rd, ns); end
        dbg_op(1'b1, 12'h004, 32'hA5A5A5A5, dc, rd);
        core_op(1'b1, 3'b010, 32'h006, 32'hFFFFFFFF, dc, rd, er, ns);
        n_vec++; if (dc !== 1 || er !== 1'b1 || ns !== 0) begin n_miss++; $display("FAIL sw_misaligned: got done=%0d err=%b strobes=%0d expected 1 1 0", dc, er, ns); end
        dbg_op(1'b0, 12'h004, 32'h0, dc, rd);
        n_vec++; if (rd !== 32'hA5A5A5A5 || dc !== 3) begin n_miss++; $display("FAIL sw_misaligned_mem: got %h done=%0d expected a5a5a5a5 3", rd, dc); end
        core_op(1'b1, 3'b100, 32'h010, 32'h0, dc, rd, er, ns);
        n_vec++; if (dc !== 1 || er !== 1'b1 || ns !== 0) begin n_miss++; $display("FAIL store_f3_100: got done=%0d err=%b strobes=%0d expected 1 1 0", dc, er, ns); end
    endtask

    task automatic test_contention();
        int dc, ns; logic [31:0] rd; logic er; logic f, s, b;
        dbg_op(1'b0, 12'h010, 32'h0, dc, rd);
        contend(f, s, b);
        n_vec++; if (f !== 1'b1 || s !== 1'b0 || b !== 1'b0) begin n_miss++; $display("FAIL contend_1: got first_core=%b second_core=%b both=%b expected 1 0 0", f, s, b); end
        core_op(1'b0, 3'b010, 32'h010, 32'h0, dc, rd, er, ns);
        contend(f, s, b);
        n_vec++; if (f !== 1'b0 || s !== 1'b1 || b !== 1'b0) begin n_miss++; $display("FAIL contend_2: got first_core=%b second_core=%b both=%b expected 0 1 0", f, s, b); end
    endtask

    task automatic test_reset_mid_access();
        int dc, ns, cyc, ndone; logic [31:0] rd;
        dbg_op(1'b1, 12'h100, 32'h55AA55AA, dc, rd);
        @(negedge clk);
        core_req = 1'b1; core_we = 1'b1; core_f3 = 3'b010; core_addr = 32'h100; core_wdata = 32'hCAFEF00D;
        #1;
        cyc = 0;
        while (!o_core_gnt && cyc < 20) begin @(negedge clk); #1; cyc++; end
        @(negedge clk);
        #1;
        n_vec++; if (o_mem_word !== 1'b1 || o_mem_we !== 1'b1 || o_mem_addr !== 12'h100) begin n_miss++; $display("FAIL rst_access_live: got word=%b we=%b addr=%h expected 1 1 100", o_mem_word, o_mem_we, o_mem_addr); end
        rst_n = 1'b0;
        #1;
        n_vec++; if ({o_mem_we, o_mem_byte, o_mem_half, o_mem_word, o_core_done} !== 5'b0 || o_mem_addr !== 12'd0 || o_mem_wdata !== 32'd0) begin n_miss++; $display("FAIL rst_async_outputs: got %b addr=%h wdata=%h expected zeros", {o_mem_we, o_mem_byte, o_mem_half, o_mem_word, o_core_done}, o_mem_addr, o_mem_wdata); end
        core_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 6; c++) begin @(negedge clk); #1; if (o_core_done) ndone++; end
        n_vec++; if (ndone !== 0) begin n_miss++; $display("FAIL rst_no_done: got %0d done pulses expected 0", ndone); end
        dbg_op(1'b0, 12'h100, 32'h0, dc, rd);
        n_vec++; if (rd !== 32'h55AA55AA) begin n_miss++; $display("FAIL rst_not_committed: got %h expected 55aa55aa", rd); end
    endtask

    task automatic test_aliasing();
        int dc, ns; logic [31:0] rd; logic er;
        core_op(1'b1, 3'b010, 32'h00001000, 32'h11223344, dc, rd, er, ns);
        n_vec++; if (dc !== 2 || er !== 1'b0) begin n_miss++; $display("FAIL alias_sw: got done=%0d err=%b expected 2 0", dc, er); end
        dbg_op(1'b0, 12'h000, 32'h0, dc, rd);
        n_vec++; if (rd !== 32'h11223344) begin n_miss++; $display("FAIL alias_read: got %h expected 11223344", rd); end
    endtask

    task automatic test_back_to_back();
        int dc, ns; logic [31:0] rd; logic er;
        dbg_op(1'b1, 12'h203, 32'h0BADF00D, dc, rd);
        n_vec++; if (dc !== 2) begin n_miss++; $display("FAIL dbg_write_timing: got done=%0d expected 2", dc); end
        core_op(1'b0, 3'b010, 32'h200, 32'h0, dc, rd, er, ns);
        n_vec++; if (rd !== 32'h0BADF00D || er !== 1'b0) begin n_miss++; $display("FAIL dbg_addr_forced: got %h err=%b expected 0badf00d 0", rd, er); end
        core_op(1'b1, 3'b001, 32'h202, 32'hFFFF7FFE, dc, rd, er, ns);
        core_op(1'b0, 3'b001, 32'h202, 32'h0, dc, rd, er, ns);
        n_vec++; if (rd !== 32'h00007FFE) begin n_miss++; $display("FAIL sh_lh_positive: got %h expected 00007ffe", rd); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_word_round_trip();
        test_byte_extension();
        test_errors();
        test_contention();
        test_reset_mid_access();
        test_aliasing();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
